// File: rtl/ps2_tetris_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tetris_cmd_decoder
// Purpose  : Parses PS/2 scan-code set 2 bytes (E0 extended prefix, F0 break
//            prefix) into Tetris game commands. Commands go through a
//            one-entry buffer with a valid/ready handshake. The module also
//            exports a held level for each movement/drop key.
// Ports    : inclock          - system clock
//            resetn           - asynchronous active-low reset
//            ps2_key_pressed  - one-cycle strobe, ps2_key_data valid
//            ps2_key_data     - received scan-code byte
//            cmd_ready        - consumer accepts cmd this cycle
//            clear_overflow   - synchronous clear of the overflow flag
//            cmd_valid        - command buffered, held until accepted
//            cmd_code         - 1 LEFT 2 RIGHT 3 ROTATE 4 DOWN 5 DROP 6 PAUSE
//            key_held         - [0]LEFT [1]RIGHT [2]ROTATE [3]DOWN [4]DROP
//            overflow         - sticky, a command was dropped (buffer full)
//            parse_state      - current parser state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_tetris_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17,
    parameter bit REPEAT_EN      = 1'b0
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    input  logic       cmd_ready,
    input  logic       clear_overflow,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [4:0] key_held,
    output logic       overflow,
    output logic [1:0] parse_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]       c_PFX_EXT = 8'hE0;
    localparam logic [7:0]       c_PFX_BRK = 8'hF0;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_valid;
    logic [2:0]       r_cmd_code;
    logic [4:0]       r_key_held;
    logic             r_overflow;

    // Key lookup for non-extended and extended codes
    logic       w_ne_hit, w_ex_hit;
    logic [2:0] w_ne_code, w_ex_code;
    logic [4:0] w_ne_mask, w_ex_mask;

    always_comb begin
        w_ne_hit  = 1'b1;
        w_ne_code = 3'd0;
        w_ne_mask = 5'b00000;
        case (ps2_key_data)
            8'h29:   begin w_ne_code = 3'd5; w_ne_mask = 5'b10000; end
            8'h4D:   begin w_ne_code = 3'd6; w_ne_mask = 5'b00000; end // PAUSE has no held bit
            default: w_ne_hit = 1'b0;
        endcase

        w_ex_hit  = 1'b1;
        w_ex_code = 3'd0;
        w_ex_mask = 5'b00000;
        case (ps2_key_data)
            8'h6B:   begin w_ex_code = 3'd1; w_ex_mask = 5'b00001; end
            8'h74:   begin w_ex_code = 3'd2; w_ex_mask = 5'b00010; end
            8'h75:   begin w_ex_code = 3'd3; w_ex_mask = 5'b00100; end
            8'h72:   begin w_ex_code = 3'd4; w_ex_mask = 5'b01000; end
            default: w_ex_hit = 1'b0;
        endcase
    end

    // Parser next-state, timeout counter, held levels and command request
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [4:0]       w_held_nxt;
    logic             w_mk;
    logic [2:0]       w_mk_code;
    logic [4:0]       w_mk_mask;
    logic             w_req;
    logic [2:0]       w_req_code;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_held_nxt  = r_key_held;
        w_mk        = 1'b0;
        w_mk_code   = 3'd0;
        w_mk_mask   = 5'b00000;
        w_req       = 1'b0;
        w_req_code  = 3'd0;

        if (ps2_key_pressed) begin
            // A strobe always takes priority over an expiring timeout
            w_cnt_nxt = '0;
            case (r_state)
                ST_IDLE: begin
                    if (ps2_key_data == c_PFX_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (ps2_key_data == c_PFX_BRK) begin
                        w_state_nxt = ST_BRK;
                    end else begin
                        w_mk      = w_ne_hit;
                        w_mk_code = w_ne_code;
                        w_mk_mask = w_ne_mask;
                    end
                end
                ST_EXT: begin
                    if (ps2_key_data == c_PFX_BRK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (ps2_key_data != c_PFX_EXT) begin
                        w_state_nxt = ST_IDLE;
                        w_mk        = w_ex_hit;
                        w_mk_code   = w_ex_code;
                        w_mk_mask   = w_ex_mask;
                    end
                end
                ST_BRK: begin
                    w_state_nxt = ST_IDLE;
                    w_held_nxt  = r_key_held & ~w_ne_mask;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_held_nxt  = r_key_held & ~w_ex_mask;
                end
            endcase
        end else if (r_state == ST_IDLE) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        // Typematic repeats of an already-held key are suppressed unless enabled
        if (w_mk) begin
            if (REPEAT_EN || ((r_key_held & w_mk_mask) == 5'b00000)) begin
                w_req      = 1'b1;
                w_req_code = w_mk_code;
            end
            w_held_nxt = w_held_nxt | w_mk_mask;
        end
    end

    logic w_accept;
    assign w_accept = r_cmd_valid && cmd_ready;

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 3'd0;
            r_key_held  <= 5'b00000;
            r_overflow  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_key_held <= w_held_nxt;

            // Load when empty or when the held entry leaves this same cycle
            if (w_req && (!r_cmd_valid || cmd_ready)) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= w_req_code;
            end else if (w_accept) begin
                r_cmd_valid <= 1'b0;
                r_cmd_code  <= 3'd0;
            end

            // A drop in the same cycle as a clear leaves the flag set
            if (w_req && r_cmd_valid && !cmd_ready) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_code    = r_cmd_code;
    assign key_held    = r_key_held;
    assign overflow    = r_overflow;
    assign parse_state = r_state;

endmodule
`default_nettype wire
